// File: rtl/pwm_pkg.sv
// Shared constants for the dead-time gate driver: one-hot state indices and default widths.
// Optional fault latch is enabled in the consumers by defining PWM_DEADTIME_FAULT_EN.
package pwm_pkg;
  localparam int DT_BITS_DEF = 8;

  localparam int S_OFF    = 0;
  localparam int S_DEAD_H = 1;
  localparam int S_HI     = 2;
  localparam int S_DEAD_L = 3;
  localparam int S_LO     = 4;

  typedef enum logic [4:0] {
    ST_OFF    = 5'(1 << S_OFF),
    ST_DEAD_H = 5'(1 << S_DEAD_H),
    ST_HI     = 5'(1 << S_HI),
    ST_DEAD_L = 5'(1 << S_DEAD_L),
    ST_LO     = 5'(1 << S_LO)
  } state_e;
endpackage

// File: rtl/pwm_deadtime_if.sv
// Control/gate-drive bundle between the PWM controller and pwm_deadtime.
// Fault signals exist only when PWM_DEADTIME_FAULT_EN is defined.
interface pwm_deadtime_if #(parameter int DT_BITS = pwm_pkg::DT_BITS_DEF);
  logic               pwm_i;
  logic               enable_i;
  logic [DT_BITS-1:0] dead_i;
  logic               hi_o;
  logic               lo_o;
  logic               busy_o;
`ifdef PWM_DEADTIME_FAULT_EN
  logic               fault_i;
  logic               fault_clr_i;
  logic               fault_o;

  modport master (output pwm_i, enable_i, dead_i, fault_i, fault_clr_i,
                  input  hi_o, lo_o, busy_o, fault_o);
  modport slave  (input  pwm_i, enable_i, dead_i, fault_i, fault_clr_i,
                  output hi_o, lo_o, busy_o, fault_o);
`else
  modport master (output pwm_i, enable_i, dead_i,
                  input  hi_o, lo_o, busy_o);
  modport slave  (input  pwm_i, enable_i, dead_i,
                  output hi_o, lo_o, busy_o);
`endif
endinterface

// File: rtl/pwm_dt_counter.sv
// Loadable down-counter timing the dead band; load wins over decrement.
module pwm_dt_counter #(
  parameter int DT_BITS = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               load,
  input  logic [DT_BITS-1:0] load_val,
  input  logic               dec,
  output logic               zero_o
);
  logic [DT_BITS-1:0] cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)     cnt <= '0;
    else if (load) cnt <= load_val;
    else if (dec)  cnt <= cnt - 1'b1;
  end

  assign zero_o = (cnt == '0);
endmodule

// File: rtl/pwm_deadtime.sv
// Complementary gate-drive generator with programmable dead band (dead_i+1 cycles).
// Define PWM_DEADTIME_FAULT_EN to add the latched fault shutdown.
module pwm_deadtime import pwm_pkg::*; #(
  parameter int DT_BITS = DT_BITS_DEF
) (
  input  logic          clk_i,
  input  logic          rst_i,
  pwm_deadtime_if.slave bus
);
  state_e state;
  logic   pwm_q;
  logic   run, go_dh, go_dl, load, dec, zero;

`ifdef PWM_DEADTIME_FAULT_EN
  logic fault_q;

  // Clear needs fault_i low at the same edge; a live fault keeps the latch set.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                 fault_q <= 1'b0;
    else if (bus.fault_i)      fault_q <= 1'b1;
    else if (bus.fault_clr_i)  fault_q <= 1'b0;
  end

  assign bus.fault_o = fault_q;
  assign run = bus.enable_i & ~bus.fault_i & ~fault_q;
`else
  assign run = bus.enable_i;
`endif

  // Any entry into a dead state reloads the band, including DEAD_H <-> DEAD_L flips.
  assign go_dh = run &  pwm_q & (state[S_OFF] | state[S_DEAD_L] | state[S_LO]);
  assign go_dl = run & ~pwm_q & (state[S_OFF] | state[S_DEAD_H] | state[S_HI]);
  assign load  = go_dh | go_dl;
  assign dec   = run & (state[S_DEAD_H] | state[S_DEAD_L]) & ~zero & ~load;

  pwm_dt_counter #(.DT_BITS(DT_BITS)) u_cnt (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .load     (load),
    .load_val (bus.dead_i),
    .dec      (dec),
    .zero_o   (zero)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= ST_OFF;
      pwm_q <= 1'b0;
    end else begin
      pwm_q <= bus.pwm_i;
      if (!run)                             state <= ST_OFF;
      else if (go_dh)                       state <= ST_DEAD_H;
      else if (go_dl)                       state <= ST_DEAD_L;
      else if (state == ST_DEAD_H && zero)  state <= ST_HI;
      else if (state == ST_DEAD_L && zero)  state <= ST_LO;
    end
  end

  assign bus.hi_o   = state[S_HI];
  assign bus.lo_o   = state[S_LO];
  assign bus.busy_o = state[S_DEAD_H] | state[S_DEAD_L];
endmodule

// File: tb/tb_pwm_deadtime.sv
// Scoreboard bench for pwm_deadtime: segments push hand-computed outputs, a monitor pops and compares.
// Fault segments are checked only when PWM_DEADTIME_FAULT_EN is defined.
module tb_pwm_deadtime;
  import pwm_pkg::*;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;

  pwm_deadtime_if #(.DT_BITS(DT_BITS_DEF)) bus ();

  pwm_deadtime #(.DT_BITS(DT_BITS_DEF)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus.slave)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    string name;
    logic  h, l, b, f;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_err = 0;

  function automatic logic [3:0] outs();
`ifdef PWM_DEADTIME_FAULT_EN
    return {bus.hi_o, bus.lo_o, bus.busy_o, bus.fault_o};
`else
    return {bus.hi_o, bus.lo_o, bus.busy_o, 1'b0};
`endif
  endfunction

  task automatic chk(input string name, input logic [3:0] got, input logic [3:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s @%0t: got hi/lo/busy/fault=%b want %b", name, $time, got, want);
    end
  endtask

  // Outputs are sampled 1 time unit after each active edge.
  always @(posedge clk_i) begin
    #1;
    n_vec++;
    if (bus.hi_o === 1'b1 && bus.lo_o === 1'b1) begin
      n_err++;
      $display("FAIL excl @%0t: hi_o=1 lo_o=1 want never both", $time);
    end
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      chk(mon_e.name, outs(), {mon_e.h, mon_e.l, mon_e.b, mon_e.f});
    end
  end

  // Hold inputs for n cycles; outputs after each of those edges are expected constant.
  task automatic seg(input string nm, input int n, input logic r, input logic en,
                     input logic p, input logic [7:0] d, input logic fl, input logic cl,
                     input logic eh, input logic el, input logic eb, input logic ef);
    repeat (n) begin
      @(negedge clk_i);
      rst_i        = r;
      bus.enable_i = en;
      bus.pwm_i    = p;
      bus.dead_i   = d;
`ifdef PWM_DEADTIME_FAULT_EN
      bus.fault_i     = fl;
      bus.fault_clr_i = cl;
`else
      if (fl || cl) $display("note: fault stimulus ignored in this build");
`endif
      sb.push_back('{nm, eh, el, eb, ef});
    end
  endtask

  initial begin
    bus.pwm_i    = 1'b0;
    bus.enable_i = 1'b0;
    bus.dead_i   = '0;
`ifdef PWM_DEADTIME_FAULT_EN
    bus.fault_i     = 1'b0;
    bus.fault_clr_i = 1'b0;
`endif
    //   name         n  rst en pwm dead flt clr  hi lo busy flt
    seg("reset",      3, 1, 0, 0, 0,    0, 0,   0, 0, 0, 0);
    seg("off_idle",   2, 0, 0, 0, 3,    0, 0,   0, 0, 0, 0);
    seg("en_dead_l",  4, 0, 1, 0, 3,    0, 0,   0, 0, 1, 0);
    seg("en_lo",      4, 0, 1, 0, 3,    0, 0,   0, 1, 0, 0);
    // Steady PWM, dead_i = 3: 4 both-off cycles per edge, 16 cycles of hi_o.
    seg("st_rise_lo", 1, 0, 1, 1, 3,    0, 0,   0, 1, 0, 0);
    seg("st_dead_h",  4, 0, 1, 1, 3,    0, 0,   0, 0, 1, 0);
    seg("st_hi",     15, 0, 1, 1, 3,    0, 0,   1, 0, 0, 0);
    seg("st_fall_hi", 1, 0, 1, 0, 3,    0, 0,   1, 0, 0, 0);
    seg("st_dead_l",  4, 0, 1, 0, 3,    0, 0,   0, 0, 1, 0);
    seg("st_lo",     15, 0, 1, 0, 3,    0, 0,   0, 1, 0, 0);
    // Short pulse of 3 cycles with dead_i = 4 never reaches HI.
    seg("sp_lo",      1, 0, 1, 1, 4,    0, 0,   0, 1, 0, 0);
    seg("sp_dead_h",  2, 0, 1, 1, 4,    0, 0,   0, 0, 1, 0);
    seg("sp_dead",    6, 0, 1, 0, 4,    0, 0,   0, 0, 1, 0);
    seg("sp_lo_back", 3, 0, 1, 0, 4,    0, 0,   0, 1, 0, 0);
    // Minimum dead time, period 8.
    for (int i = 0; i < 3; i++) begin
      seg("md_lo",    1, 0, 1, 1, 0,    0, 0,   0, 1, 0, 0);
      seg("md_dh",    1, 0, 1, 1, 0,    0, 0,   0, 0, 1, 0);
      seg("md_hi",    2, 0, 1, 1, 0,    0, 0,   1, 0, 0, 0);
      seg("md_hi2",   1, 0, 1, 0, 0,    0, 0,   1, 0, 0, 0);
      seg("md_dl",    1, 0, 1, 0, 0,    0, 0,   0, 0, 1, 0);
      seg("md_lo2",   2, 0, 1, 0, 0,    0, 0,   0, 1, 0, 0);
    end
    // pwm_i toggling every cycle keeps both outputs off.
    seg("tg_lo",      1, 0, 1, 1, 2,    0, 0,   0, 1, 0, 0);
    for (int i = 1; i < 8; i++)
      seg("tg_busy",  1, 0, 1, logic'(i % 2 == 0), 2, 0, 0, 0, 0, 1, 0);
    seg("tg_settle",  3, 0, 1, 0, 2,    0, 0,   0, 0, 1, 0);
    seg("tg_lo_back", 2, 0, 1, 0, 2,    0, 0,   0, 1, 0, 0);
    // Disable from HI, then re-enable with pwm high.
    seg("ds_lo",      1, 0, 1, 1, 3,    0, 0,   0, 1, 0, 0);
    seg("ds_dh",      4, 0, 1, 1, 3,    0, 0,   0, 0, 1, 0);
    seg("ds_hi",      3, 0, 1, 1, 3,    0, 0,   1, 0, 0, 0);
    seg("ds_off",     3, 0, 0, 1, 3,    0, 0,   0, 0, 0, 0);
    seg("re_dh",      4, 0, 1, 1, 3,    0, 0,   0, 0, 1, 0);
    seg("re_hi",      3, 0, 1, 1, 3,    0, 0,   1, 0, 0, 0);
    // Asynchronous reset in the middle of a band.
    seg("rb_hi",      1, 0, 1, 0, 5,    0, 0,   1, 0, 0, 0);
    seg("rb_dl",      2, 0, 1, 0, 5,    0, 0,   0, 0, 1, 0);
    @(negedge clk_i);
    rst_i = 1'b1;
    #1;
    chk("rst_async", outs(), 4'b0000);
    sb.push_back('{"rst_edge", 1'b0, 1'b0, 1'b0, 1'b0});
    seg("rst_hold",   2, 1, 1, 0, 5,    0, 0,   0, 0, 0, 0);
    seg("rst_dl",     6, 0, 1, 0, 5,    0, 0,   0, 0, 1, 0);
    seg("rst_lo",     2, 0, 1, 0, 5,    0, 0,   0, 1, 0, 0);
`ifdef PWM_DEADTIME_FAULT_EN
    seg("flt_set",    1, 0, 1, 0, 5,    1, 0,   0, 0, 0, 1);
    seg("flt_hold",   2, 0, 1, 0, 5,    0, 0,   0, 0, 0, 1);
    seg("flt_clr_blk",1, 0, 1, 0, 5,    1, 1,   0, 0, 0, 1);
    seg("flt_clr",    1, 0, 1, 0, 5,    0, 1,   0, 0, 0, 0);
    seg("flt_dead",   6, 0, 1, 0, 5,    0, 0,   0, 0, 1, 0);
    seg("flt_lo",     2, 0, 1, 0, 5,    0, 0,   0, 1, 0, 0);
`endif
    repeat (3) @(negedge clk_i);
    n_vec++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations left, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
